// File: rtl/adder_pkg.sv
// Shared types and helpers for the 2048-bit adder front end.
package adder_pkg;

  // Beats needed to carry a w-bit operand over an m-bit stream.
  function automatic int unsigned nbeats(input int unsigned w, input int unsigned m);
    return (w + m - 1) / m;
  endfunction

  typedef enum logic {
    LOAD,
    DROP
  } loader_state_e;

endpackage

// File: rtl/opnd_loader2048b_if.sv
// Beat stream in, launched operands and status out.
interface opnd_loader2048b_if #(
  parameter int unsigned W     = 2048,
  parameter int unsigned M     = 64,
  parameter int unsigned CNT_W = 16
) ();
  logic             s_valid;
  logic             s_ready;
  logic [M-1:0]     s_a;
  logic [M-1:0]     s_b;
  logic             s_cin;
  logic             s_last;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             c_in;
  logic             in_valid;
  logic             err_framing;
  logic [CNT_W-1:0] op_count;

  modport master (
    output s_valid, s_a, s_b, s_cin, s_last,
    input  s_ready, a, b, c_in, in_valid, err_framing, op_count
  );

  modport slave (
    input  s_valid, s_a, s_b, s_cin, s_last,
    output s_ready, a, b, c_in, in_valid, err_framing, op_count
  );
endinterface

// File: rtl/opnd_loader2048b_stage_buf.sv
// A/B staging buffer: one slot per beat, the final slot trimmed to the
// bits that remain of W. merged_* shows the buffer with the current beat
// already written into its slot, so a launch can use it on the last beat.
module opnd_stage_buf
  import adder_pkg::*;
#(
  parameter int unsigned W     = 2048,
  parameter int unsigned M     = 64,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [M-1:0]     din_a,
  input  logic [M-1:0]     din_b,
  output logic [W-1:0]     merged_a,
  output logic [W-1:0]     merged_b
);
  localparam int unsigned N = nbeats(W, M);

  for (genvar i = 0; i < N; i++) begin : g_word
    localparam int unsigned LO  = i * M;
    localparam int unsigned WID = ((W - LO) < M) ? (W - LO) : M;

    logic [WID-1:0] word_a;
    logic [WID-1:0] word_b;
    logic           hit;

    assign hit = (idx == IDX_W'(i));

    // Capture the low WID bits of the beat addressed to this slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_a <= '0;
        word_b <= '0;
      end else if (we && hit) begin
        word_a <= din_a[WID-1:0];
        word_b <= din_b[WID-1:0];
      end
    end

    assign merged_a[LO +: WID] = hit ? din_a[WID-1:0] : word_a;
    assign merged_b[LO +: WID] = hit ? din_b[WID-1:0] : word_b;
  end
endmodule

// File: rtl/opnd_loader2048b.sv
// Operand loader: assembles M-bit beats into W-bit operands, launches them
// to the adder with a one-cycle in_valid strobe, flags malformed frames.
module opnd_loader2048b
  import adder_pkg::*;
#(
  parameter int unsigned W     = 2048,
  parameter int unsigned M     = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  opnd_loader2048b_if.slave  bus
);
  localparam int unsigned      N     = nbeats(W, M);
  localparam int unsigned      IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  loader_state_e    state;
  logic [IDX_W-1:0] idx;
  logic             stage_cin;
  logic             accept;
  logic             merged_cin;
  logic [W-1:0]     merged_a;
  logic [W-1:0]     merged_b;

  assign accept     = bus.s_valid && bus.s_ready;
  assign merged_cin = (idx == '0) ? bus.s_cin : stage_cin;

  opnd_stage_buf #(
    .W     (W),
    .M     (M),
    .IDX_W (IDX_W)
  ) u_stage (
    .clk      (clk),
    .rst      (rst),
    .we       (accept && (state == LOAD)),
    .idx      (idx),
    .din_a    (bus.s_a),
    .din_b    (bus.s_b),
    .merged_a (merged_a),
    .merged_b (merged_b)
  );

  // Frame FSM, launch registers, status pulses and launch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= LOAD;
      idx             <= '0;
      stage_cin       <= 1'b0;
      bus.s_ready     <= 1'b0;
      bus.a           <= '0;
      bus.b           <= '0;
      bus.c_in        <= 1'b0;
      bus.in_valid    <= 1'b0;
      bus.err_framing <= 1'b0;
      bus.op_count    <= '0;
    end else begin
      bus.s_ready     <= 1'b1;
      bus.in_valid    <= 1'b0;
      bus.err_framing <= 1'b0;
      if (accept) begin
        case (state)
          LOAD: begin
            if (idx == '0) stage_cin <= bus.s_cin;
            if (idx == LAST) begin
              idx <= '0;
              if (bus.s_last) begin
                bus.a        <= merged_a;
                bus.b        <= merged_b;
                bus.c_in     <= merged_cin;
                bus.in_valid <= 1'b1;
                bus.op_count <= bus.op_count + CNT_W'(1);
              end else begin
                bus.err_framing <= 1'b1;
                state           <= DROP;
              end
            end else if (bus.s_last) begin
              bus.err_framing <= 1'b1;
              idx             <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          DROP: begin
            if (bus.s_last) state <= LOAD;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_opnd_loader2048b.sv
// Directed bench for opnd_loader2048b: table of frames on a W=2048 instance,
// plus hand sequences for back-to-back, W=2000 trimming and mid-frame reset.
module tb_opnd_loader2048b;
  localparam int unsigned W0    = 2048;
  localparam int unsigned W1    = 2000;
  localparam int unsigned M     = 64;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  opnd_loader2048b_if #(.W(W0), .M(M), .CNT_W(CNT_W)) bus0 ();
  opnd_loader2048b_if #(.W(W1), .M(M), .CNT_W(CNT_W)) bus1 ();

  opnd_loader2048b #(.W(W0), .M(M), .CNT_W(CNT_W)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  opnd_loader2048b #(.W(W1), .M(M), .CNT_W(CNT_W)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ecount = 0;
  int launches = 0;
  int errs = 0;
  int launch_e = 0;
  int err_e = 0;

  // Edge counter and pulse monitor for u0.
  always @(posedge clk) ecount <= ecount + 1;
  always @(negedge clk) begin
    if (bus0.in_valid === 1'b1) begin
      launches <= launches + 1;
      launch_e <= ecount;
    end
    if (bus0.err_framing === 1'b1) begin
      errs  <= errs + 1;
      err_e <= ecount;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    logic [63:0] wa, we;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < 32; k++) begin
        wa = act[64*k +: 64];
        we = exp[64*k +: 64];
        if (wa !== we) begin
          $display("FAIL %s word %0d: got %h expected %h", name, k, wa, we);
          break;
        end
      end
    end
  endtask

  function automatic logic [2047:0] build(input logic [63:0] seed, input bit inv);
    logic [2047:0] v;
    logic [63:0]   w;
    for (int k = 0; k < 32; k++) begin
      w = seed + 64'(k);
      v[64*k +: 64] = inv ? ~w : w;
    end
    return v;
  endfunction

  // Drive one frame on u0; beats other than 0 carry ~cin on s_cin.
  task automatic send_frame(input int nb, input int last_at, input int gap, input logic cin,
                            input logic [63:0] seed, input int tag_beat,
                            output int last_e, output int tag_e);
    last_e = 0;
    tag_e  = 0;
    for (int k = 0; k < nb; k++) begin
      bus0.s_valid = 1'b1;
      bus0.s_a     = seed + 64'(k);
      bus0.s_b     = ~(seed + 64'(k));
      bus0.s_cin   = (k == 0) ? cin : ~cin;
      bus0.s_last  = (k == last_at);
      @(posedge clk); #1;
      last_e = ecount;
      if (k == tag_beat) tag_e = ecount;
      if (gap > 0) begin
        bus0.s_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
  endtask

  typedef struct {
    int          nb;
    int          last_at;
    int          gap;
    logic        cin;
    logic [63:0] seed;
    int          err_beat;
    bit          exp_launch;
    bit          exp_err;
    int          exp_count;
  } vec_t;

  vec_t vecs[6];

  logic [2047:0] exp_a, exp_b, exp_a1, exp_b1, frame1_a;
  logic          exp_cin;

  initial begin
    int l0, e0, last_e, tag_e, bad_stable, bad_iv, e31, e63;

    //          nb  last gap cin seed                       errb  L  E  cnt
    vecs[0] = '{32, 31, 0, 1'b1, 64'h0,                     -1,   1, 0, 1};
    vecs[1] = '{10,  9, 0, 1'b0, 64'hAAAA_0000,              9,   0, 1, 1};
    vecs[2] = '{32, 31, 0, 1'b0, 64'h100,                   -1,   1, 0, 2};
    vecs[3] = '{35, 34, 0, 1'b1, 64'hBEEF,                  31,   0, 1, 2};
    vecs[4] = '{32, 31, 2, 1'b1, 64'h5555_5555_0000_0000,   -1,   1, 0, 3};
    vecs[5] = '{32, 31, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0,   -1,   1, 0, 4};

    rst = 1'b1;
    bus0.s_valid = 1'b0; bus0.s_a = '0; bus0.s_b = '0; bus0.s_cin = 1'b0; bus0.s_last = 1'b0;
    bus1.s_valid = 1'b0; bus1.s_a = '0; bus1.s_b = '0; bus1.s_cin = 1'b0; bus1.s_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_s_ready", 64'(bus0.s_ready), 64'd0);
    chk("rst_in_valid", 64'(bus0.in_valid), 64'd0);
    chk("rst_err", 64'(bus0.err_framing), 64'd0);
    chk("rst_op_count", 64'(bus0.op_count), 64'd0);
    chk_wide("rst_a", bus0.a, '0);
    chk("rst_c_in", 64'(bus0.c_in), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(bus0.s_ready), 64'd1);

    exp_a = '0; exp_b = '0; exp_cin = 1'b0;
    for (int v = 0; v < 6; v++) begin
      l0 = launches;
      e0 = errs;
      chk("vec_ready", 64'(bus0.s_ready), 64'd1);
      send_frame(vecs[v].nb, vecs[v].last_at, vecs[v].gap, vecs[v].cin, vecs[v].seed,
                 vecs[v].err_beat, last_e, tag_e);
      repeat (2) begin
        @(posedge clk); #1;
      end
      chk("vec_launches", 64'(launches - l0), 64'(vecs[v].exp_launch));
      chk("vec_errs", 64'(errs - e0), 64'(vecs[v].exp_err));
      if (vecs[v].exp_launch) begin
        exp_a   = build(vecs[v].seed, 1'b0);
        exp_b   = build(vecs[v].seed, 1'b1);
        exp_cin = vecs[v].cin;
        chk("vec_launch_lat", 64'(launch_e), 64'(last_e));
      end
      if (vecs[v].exp_err) chk("vec_err_lat", 64'(err_e), 64'(tag_e));
      chk_wide("vec_a", bus0.a, exp_a);
      chk_wide("vec_b", bus0.b, exp_b);
      chk("vec_c_in", 64'(bus0.c_in), 64'(exp_cin));
      chk("vec_op_count", 64'(bus0.op_count), 64'(vecs[v].exp_count));
    end

    // Back-to-back frames, s_valid high for 64 cycles.
    l0 = launches;
    bad_stable = 0;
    bad_iv = 0;
    e31 = 0;
    e63 = 0;
    frame1_a = build(64'h1000, 1'b0);
    for (int k = 0; k < 64; k++) begin
      bus0.s_valid = 1'b1;
      bus0.s_a     = ((k < 32) ? 64'h1000 : 64'h2000) + 64'(k % 32);
      bus0.s_b     = ~bus0.s_a;
      bus0.s_cin   = (k == 32);
      bus0.s_last  = ((k % 32) == 31);
      @(posedge clk); #1;
      if (k == 31) e31 = ecount;
      if (k == 63) e63 = ecount;
      if (bus0.in_valid !== ((k % 32) == 31)) bad_iv++;
      if (k >= 31 && k < 63 && bus0.a !== frame1_a) bad_stable++;
    end
    bus0.s_valid = 1'b0;
    bus0.s_last  = 1'b0;
    @(posedge clk); #1;
    chk("b2b_in_valid_pattern", 64'(bad_iv), 64'd0);
    chk("b2b_a_stable", 64'(bad_stable), 64'd0);
    chk("b2b_launches", 64'(launches - l0), 64'd2);
    chk("b2b_spacing", 64'(e63 - e31), 64'd32);
    chk_wide("b2b_a", bus0.a, build(64'h2000, 1'b0));
    chk("b2b_c_in", 64'(bus0.c_in), 64'd1);
    chk("b2b_op_count", 64'(bus0.op_count), 64'd6);

    // W=2000: last beat only contributes its low 16 bits.
    exp_a1 = build(64'h0, 1'b0);
    exp_b1 = build(64'h0, 1'b1);
    exp_a1[64*31 +: 64] = '1;
    exp_b1[64*31 +: 64] = 64'h1234_5678_9ABC_DEF0;
    exp_a1[2047:2000] = '0;
    exp_b1[2047:2000] = '0;
    bad_iv = 0;
    for (int k = 0; k < 32; k++) begin
      bus1.s_valid = 1'b1;
      bus1.s_a     = (k == 31) ? '1 : 64'(k);
      bus1.s_b     = (k == 31) ? 64'h1234_5678_9ABC_DEF0 : ~64'(k);
      bus1.s_cin   = (k != 0);
      bus1.s_last  = (k == 31);
      @(posedge clk); #1;
      if (bus1.in_valid !== (k == 31)) bad_iv++;
    end
    bus1.s_valid = 1'b0;
    bus1.s_last  = 1'b0;
    @(posedge clk); #1;
    chk("w2000_in_valid", 64'(bad_iv), 64'd0);
    chk("w2000_a_top", 64'(bus1.a[1999:1984]), 64'hFFFF);
    chk("w2000_b_top", 64'(bus1.b[1999:1984]), 64'hDEF0);
    chk_wide("w2000_a", {48'b0, bus1.a}, exp_a1);
    chk_wide("w2000_b", {48'b0, bus1.b}, exp_b1);
    chk("w2000_c_in", 64'(bus1.c_in), 64'd0);
    chk("w2000_op_count", 64'(bus1.op_count), 64'd1);

    // Reset mid-frame, then a full frame.
    l0 = launches;
    e0 = errs;
    send_frame(21, -1, 0, 1'b0, 64'h3000, -1, last_e, tag_e);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_s_ready", 64'(bus0.s_ready), 64'd0);
    chk("mid_rst_op_count", 64'(bus0.op_count), 64'd0);
    chk_wide("mid_rst_a", bus0.a, '0);
    rst = 1'b0;
    chk("post_rst_ready_low", 64'(bus0.s_ready), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_ready_high", 64'(bus0.s_ready), 64'd1);
    chk("abort_no_launch", 64'(launches - l0), 64'd0);
    send_frame(32, 31, 0, 1'b1, 64'h77, -1, last_e, tag_e);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("rst_frame_launches", 64'(launches - l0), 64'd1);
    chk("rst_frame_errs", 64'(errs - e0), 64'd0);
    chk("rst_frame_lat", 64'(launch_e), 64'(last_e));
    chk_wide("rst_frame_a", bus0.a, build(64'h77, 1'b0));
    chk_wide("rst_frame_b", bus0.b, build(64'h77, 1'b1));
    chk("rst_frame_c_in", 64'(bus0.c_in), 64'd1);
    chk("rst_frame_op_count", 64'(bus0.op_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/opnd_loader2048b.md
Name: opnd_loader2048b

Overview:
Upstream operand loader for the 2048-bit pipelined adder. It accepts narrow M-bit operand beats (A and B words side by side) over a valid/ready stream, LSB word first. It assembles full W-bit operands in a staging buffer, then launches them to the adder as stable a/b/c_in registers with a single-cycle in_valid pulse. It also checks frame length and counts launched operations.

Parameters:
W, 2048, operand width in bits
M, 64, beat width in bits; N = ceil(W/M) beats per frame
CNT_W, 16, width of op_count

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  beat valid
s_ready  out  1  beat accepted when s_valid && s_ready
s_a  in  M  A word for current beat
s_b  in  M  B word for current beat
s_cin  in  1  carry-in; sampled on beat 0 only
s_last  in  1  final beat of frame
a  out  W  launched operand A, to adder a
b  out  W  launched operand B, to adder b
c_in  out  1  launched carry-in, to adder c_in
in_valid  out  1  single-cycle launch strobe, to adder in_valid
err_framing  out  1  single-cycle pulse on a malformed frame
op_count  out  CNT_W  number of launches since reset

Behaviour:
- Reset: clk and rst are as decided above (rst synchronous, active-high). On reset: a=0, b=0, c_in=0, in_valid=0, err_framing=0, op_count=0, beat index=0, state=LOAD, s_ready=0. Reset mid-frame discards the partial frame with no launch.
- s_ready is a registered version of ~rst. It is 0 during reset and for the first cycle after rst deasserts, then 1 permanently. The adder has no backpressure, so the loader never stalls.
- Staging: beat i writes stage_a[i*M +: M] and stage_b[i*M +: M]. For the partial final beat (W mod M != 0), only the low W-(N-1)*M bits are used; upper bits of s_a/s_b are ignored. On beat 0, s_cin is latched into stage_cin.
- States:
  - LOAD: accepts beats and increments the beat index.
  - DROP: discards beats until the s_last beat is accepted (inclusive), then returns to LOAD with index 0.
- Good frame (s_last=1 exactly on beat N-1): at that edge, a/b/c_in load the staging contents merged with the current beat, and the index returns to 0. in_valid=1 in the following cycle only, and op_count increments in the same cycle.
  - Latency: in_valid is asserted 1 cycle after the final beat is accepted.
- a/b/c_in hold stable until the next launch. Staging for the next frame proceeds concurrently, and beat 0 of the next frame may be accepted in the same cycle in_valid is high. Minimum launch spacing is N cycles.
- Short frame (s_last=1 on beat index < N-1): no launch. err_framing pulses 1 cycle after that beat. Index resets to 0, state stays LOAD.
- Long frame (beat N-1 with s_last=0): no launch. err_framing pulses 1 cycle after that beat, and the state goes to DROP.
  - A beat in DROP with s_last=1 returns to LOAD with no further error pulse.
- N==1: every accepted beat with s_last=1 launches. A beat with s_last=0 is a long-frame error and enters DROP.
- s_valid=0 between beats is legal. The index and staging buffer hold their values.
- op_count wraps from 2^CNT_W-1 to 0.
- a/b/c_in are never changed by erroneous or partial frames.

Decomposition:
- Package adder_pkg holds:
  - localparam function nbeats(W,M)
  - loader_state_e enum {LOAD, DROP}
- One natural sub-module: opnd_stage_buf, the W-bit A/B staging buffer with indexed M-bit write and partial-last-word masking.
- Control FSM, launch registers and counter stay in the top.

Test Plan:
1. W=2048, M=64. Send 32 beats with s_a=beat idx, s_b=~idx, s_cin=1 on beat 0, s_last on beat 31 -> in_valid high exactly 1 cycle after beat 31; a[64*k+:64]=k; c_in=1; op_count=1.
2. Back-to-back: two frames with s_valid held high for 64 cycles -> in_valid pulses at cycles 32 and 64. a stays stable from frame 1 through the 32 cycles of frame 2 loading. op_count=2.
3. Short frame: s_last on beat 9 -> err_framing pulse, no in_valid, a unchanged. The next good frame launches normally.
4. Long frame: beat 31 with s_last=0, then 3 more beats with s_last on the 3rd -> one err_framing pulse, no launch. The following good frame launches correctly with index 0.
5. W=2000, M=64 (N=32, last beat uses 16 bits). Last beat s_a=all ones -> a[1999:1984]=0xFFFF; upper s_a bits are ignored.
6. Reset asserted after beat 20 of a frame, then a full frame -> no launch from the aborted frame. s_ready=0 for one cycle after reset; the new frame launches with op_count=1.
